// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths, FSM states and error constant for seq_div_40by8
package div_pkg;

  localparam int DIVIDEND_W = 40;
  localparam int DIVISOR_W  = 8;
  localparam int QUOTIENT_W = 32;
  localparam int CNT_W      = 5;

  localparam logic [CNT_W-1:0]      LAST_ITER    = CNT_W'(QUOTIENT_W - 1);
  localparam logic [QUOTIENT_W-1:0] ERR_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step (shift in a bit, trial subtract)
module div_step
  import div_pkg::*;
(
  input  logic [DIVISOR_W:0]   r,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   r_next,
  output logic                 qbit
);

  // t keeps r[8] as its top bit so the compare stays exact even for out-of-range operands;
  // under the valid-operand precondition r[8] is always 0 and t[9] never sets.
  logic [DIVISOR_W+1:0] t;

  // Shift the next dividend bit in and subtract the divisor when it fits.
  always_comb begin
    t      = {r, bit_in};
    r_next = t[DIVISOR_W:0];
    qbit   = 1'b0;
    if (t >= {2'b00, divisor}) begin
      r_next = t[DIVISOR_W:0] - {1'b0, divisor};
      qbit   = 1'b1;
    end
  end

endmodule

// File: rtl/seq_div_40by8.sv
// rtl/seq_div_40by8.sv - 40/8 sequential restoring divider; DIV_ERR_CHECK_EN enables divide-by-zero/overflow detection
module seq_div_40by8
  import div_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [QUOTIENT_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  err
);

  state_t                  state, state_next;
  logic [DIVISOR_W:0]      r;
  logic [QUOTIENT_W-1:0]   sreg;
  logic [DIVISOR_W-1:0]    div_q;
  logic [CNT_W-1:0]        cnt;
  logic                    accept;
  logic                    bad_ops;
  logic                    last_iter;
  logic [DIVISOR_W:0]      r_next;
  logic                    qbit;

  assign last_iter = (cnt == LAST_ITER);

`ifdef DIV_ERR_CHECK_EN
  // Quotient would not fit in 32 bits (or divisor is zero): short-circuit to DONE.
  assign bad_ops = (divisor == '0) || (dividend[DIVIDEND_W-1:QUOTIENT_W] >= divisor);
`else
  assign bad_ops = 1'b0;
`endif

  div_step u_step (
    .r       (r),
    .bit_in  (sreg[QUOTIENT_W-1]),
    .divisor (div_q),
    .r_next  (r_next),
    .qbit    (qbit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state, handshake outputs and start acceptance.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = bad_ops ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = bad_ops ? DONE : RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, per-cycle iteration and result capture on the final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r         <= '0;
      sreg      <= '0;
      div_q     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept) begin
      r     <= {1'b0, dividend[DIVIDEND_W-1:QUOTIENT_W]};
      sreg  <= dividend[QUOTIENT_W-1:0];
      div_q <= divisor;
      cnt   <= '0;
      if (bad_ops) begin
        quotient  <= ERR_QUOTIENT;
        remainder <= '0;
      end
    end else if (state == RUN) begin
      r    <= r_next;
      sreg <= {sreg[QUOTIENT_W-2:0], qbit};
      cnt  <= cnt + 1'b1;
      if (last_iter) begin
        quotient  <= {sreg[QUOTIENT_W-2:0], qbit};
        remainder <= r_next[DIVISOR_W-1:0];
      end
    end
  end

`ifdef DIV_ERR_CHECK_EN
  logic err_q;

  // Error flag follows the operand check of the most recent accepted start.
  always_ff @(posedge clk) begin
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= bad_ops;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_div_40by8.sv
// tb/tb_seq_div_40by8.sv - scoreboard bench for seq_div_40by8
module tb_seq_div_40by8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [39:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [7:0]  remainder;
  logic        err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] q;
    logic [7:0]  r;
    logic        e;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  seq_div_40by8 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .err       (err)
  );

  task automatic push_exp(input logic [39:0] dd, input logic [7:0] dv);
    exp_t        x;
    logic [39:0] qq;
    logic [39:0] rr;
    qq  = dd / {32'd0, dv};
    rr  = dd % {32'd0, dv};
    x.q = qq[31:0];
    x.r = rr[7:0];
    x.e = 1'b0;
    sb.push_back(x);
  endtask

  task automatic do_start(input logic [39:0] dd, input logic [7:0] dv);
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (!done && n < max) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) n = -1;
  endtask

  task automatic pop_compare(input string name);
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty at done", name);
    end else begin
      x = sb.pop_front();
      if (quotient !== x.q || remainder !== x.r || err !== x.e) begin
        errors++;
        $display("FAIL %s: got q=%h r=%h err=%b, expected q=%h r=%h err=%b",
                 name, quotient, remainder, err, x.q, x.r, x.e);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got busy/done/err=%b%b%b, expected 000", busy, done, err);
    end
    checks++;
    if (quotient !== 32'h0 || remainder !== 8'h0) begin
      errors++;
      $display("FAIL reset_result: got q=%h r=%h, expected 0/0", quotient, remainder);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_known;
    logic [39:0] dds[2] = '{40'h00_0000_0064, 40'hFE_FFFF_FFFF};
    logic [7:0]  dvs[2] = '{8'h07, 8'hFF};
    logic [31:0] qs[2]  = '{32'h0000_000E, 32'hFFFF_FFFF};
    logic [7:0]  rs[2]  = '{8'h02, 8'hFE};
    int n;
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      x.q = qs[i]; x.r = rs[i]; x.e = 1'b0;
      sb.push_back(x);
      do_start(dds[i], dvs[i]);
      wait_done(40, n);
      checks++;
      if (n !== 32) begin
        errors++;
        $display("FAIL known_latency[%0d]: got %0d cycles, expected 32", i, n);
      end
      pop_compare("known_result");
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || quotient !== qs[i]) begin
        errors++;
        $display("FAIL known_hold[%0d]: got done=%b q=%h, expected done=0 q=%h", i, done, quotient, qs[i]);
      end
    end
  endtask

`ifdef DIV_ERR_CHECK_EN
  task automatic test_err;
    logic [39:0] dds[2] = '{40'h12_3456_789A, 40'h05_0000_0000};
    logic [7:0]  dvs[2] = '{8'h00, 8'h05};
    int n;
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      x.q = 32'hFFFF_FFFF; x.r = 8'h00; x.e = 1'b1;
      sb.push_back(x);
      do_start(dds[i], dvs[i]);
      wait_done(40, n);
      checks++;
      if (n !== 0) begin
        errors++;
        $display("FAIL err_latency[%0d]: got %0d cycles after accept edge, expected 0", i, n);
      end
      pop_compare("err_result");
    end
    push_exp(40'h00_0000_0064, 8'h07);
    do_start(40'h00_0000_0064, 8'h07);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got err=%b, expected 0", err);
    end
    wait_done(40, n);
    pop_compare("err_recover");
  endtask
`endif

  task automatic test_restart_ignored;
    int n;
    push_exp(40'h00_0000_0064, 8'h07);
    do_start(40'h00_0000_0064, 8'h07);
    repeat (9) begin @(posedge clk); #1; end
    @(negedge clk);
    dividend = 40'h00_1234_5678;
    divisor  = 8'h33;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL restart_busy: got busy=%b done=%b, expected 1/0", busy, done);
    end
    wait_done(40, n);
    checks++;
    if (n < 0 || n + 10 !== 32) begin
      errors++;
      $display("FAIL restart_latency: got %0d cycles, expected 32", (n < 0) ? n : n + 10);
    end
    pop_compare("restart_result");
  endtask

  task automatic test_back_to_back;
    int n;
    int m;
    push_exp(40'h00_0000_0064, 8'h07);
    push_exp(40'hFE_FFFF_FFFF, 8'hFF);
    @(negedge clk);
    dividend = 40'h00_0000_0064;
    divisor  = 8'h07;
    start    = 1'b1;
    @(posedge clk);
    #1;
    dividend = 40'hFE_FFFF_FFFF;
    divisor  = 8'hFF;
    wait_done(40, n);
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL b2b_first_latency: got %0d, expected 32", n);
    end
    pop_compare("b2b_first");
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_handoff: got done=%b busy=%b, expected 0/1", done, busy);
    end
    wait_done(40, m);
    checks++;
    if (m < 0 || m + 1 !== 33) begin
      errors++;
      $display("FAIL b2b_second_latency: got %0d, expected 33", (m < 0) ? m : m + 1);
    end
    pop_compare("b2b_second");
  endtask

  task automatic test_rst_mid_run;
    int n;
    int seen = 0;
    do_start(40'hFE_FFFF_FFFF, 8'hFF);
    repeat (14) begin @(posedge clk); #1; end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err} !== 3'b000 || quotient !== 32'h0 || remainder !== 8'h0) begin
      errors++;
      $display("FAIL rst_abort: got busy=%b done=%b err=%b q=%h r=%h, expected all 0",
               busy, done, err, quotient, remainder);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_no_done: got %0d done pulses, expected 0", seen);
    end
    push_exp(40'h00_0000_0064, 8'h07);
    do_start(40'h00_0000_0064, 8'h07);
    wait_done(40, n);
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL rst_fresh_latency: got %0d, expected 32", n);
    end
    pop_compare("rst_fresh");
  endtask

  task automatic test_random;
    logic [7:0]  dv;
    logic [7:0]  hi;
    logic [39:0] dd;
    logic [39:0] recon;
    int n;
    for (int i = 0; i < 1000; i++) begin
      dv = 8'($urandom_range(255, 1));
      hi = 8'($urandom_range(int'(dv) - 1, 0));
      dd = {hi, 32'($urandom)};
      push_exp(dd, dv);
      do_start(dd, dv);
      wait_done(40, n);
      checks++;
      if (n !== 32) begin
        errors++;
        $display("FAIL rand_latency[%0d]: got %0d, expected 32", i, n);
      end
      pop_compare("rand_result");
      recon = {8'd0, quotient} * {32'd0, dv} + {32'd0, remainder};
      checks++;
      if (recon !== dd || remainder >= dv) begin
        errors++;
        $display("FAIL rand_identity[%0d]: got q*d+r=%h r=%h, expected %h with r<%h",
                 i, recon, remainder, dd, dv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_known();
`ifdef DIV_ERR_CHECK_EN
    test_err();
`endif
    test_restart_ignored();
    test_back_to_back();
    test_rst_mid_run();
    test_random();
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
